cntr_mod_n_prog: RTL and testbench

Programmable modulo-N event counter with run control. A generalised successor to the team's fixed mod-n overflow counter: parametrised width, runtime terminal value, up/down direction, one-shot or continuous mode, parallel load, sticky overflow and a saturating wrap counter. Used as a general timebase and event-count engine beside the datapath, with all control from a register block.

---
 rtl/cntr_mod_n_prog_pkg.sv | 22 ++
 rtl/cntr_mod_n_prog_if.sv | 33 +++
 rtl/cntr_wrap_sat.sv | 25 ++
 rtl/cntr_mod_n_prog.sv | 107 ++++++++++
 tb/tb_cntr_mod_n_prog.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cntr_mod_n_prog_pkg.sv
// Shared types and constants for the programmable modulo-N counter.
package cntr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cntr_state_e;

    localparam int unsigned CNTR_DW = 8;

    // Observable counter snapshot at the default width
    typedef struct packed {
        logic [CNTR_DW-1:0] count;
        logic               tc;
        logic               ovf;
    } cntr_t;

    localparam logic CNT_UP = 1'b0;
    localparam logic CNT_DN = 1'b1;

endpackage

// File: rtl/cntr_mod_n_prog_if.sv
// Control/status bundle between the register block and the counter.
interface cntr_mod_n_prog_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned WW = 4
);
    logic          i_enb;
    logic          i_clr;
    logic          i_load;
    logic [DW-1:0] i_load_val;
    logic          i_start;
    logic [DW-1:0] i_top;
    logic          i_dir;
    logic          i_oneshot;
    logic          i_ovf_clr;
    logic [DW-1:0] o_count;
    logic          o_tc;
    logic          o_ovf;
    logic [WW-1:0] o_wraps;
    logic          o_busy;
    logic          o_done;

    modport master (
        output i_enb, i_clr, i_load, i_load_val, i_start, i_top, i_dir,
               i_oneshot, i_ovf_clr,
        input  o_count, o_tc, o_ovf, o_wraps, o_busy, o_done
    );

    modport slave (
        input  i_enb, i_clr, i_load, i_load_val, i_start, i_top, i_dir,
               i_oneshot, i_ovf_clr,
        output o_count, o_tc, o_ovf, o_wraps, o_busy, o_done
    );
endinterface

// File: rtl/cntr_wrap_sat.sv
// Saturating event counter: counts i_inc pulses, sticks at all-ones.
module cntr_wrap_sat #(
    parameter int unsigned WW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [WW-1:0] o_val
);
    logic [WW-1:0] r_val;

    // Clear has priority over increment; increment stops at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val <= '0;
        end else if (i_clr) begin
            r_val <= '0;
        end else if (i_inc && (r_val != '1)) begin
            r_val <= r_val + WW'(1);
        end
    end

    assign o_val = r_val;
endmodule

// File: rtl/cntr_mod_n_prog.sv
// Programmable modulo-N event counter with run control, load and wrap stats.
module cntr_mod_n_prog
    import cntr_pkg::*;
#(
    parameter int unsigned DW = 8,
    parameter int unsigned WW = 4
) (
    input  logic                clk,
    input  logic                rst,
    cntr_mod_n_prog_if.slave    bus
);
    cntr_state_e   r_state, w_state_nxt;
    logic [DW-1:0] r_count, w_count_nxt;
    logic [DW-1:0] r_top,   w_top_nxt;
    logic          r_dir,   w_dir_nxt;
    logic          r_os,    w_os_nxt;
    logic          r_ovf;
    logic          w_at_term;
    logic          w_wrap;
    logic [DW-1:0] w_load_clamped;
    logic [WW-1:0] w_wraps;

    // Terminal position for the latched direction and the clamped load value
    always_comb begin
        w_at_term      = (r_dir == CNT_DN) ? (r_count == '0) : (r_count >= r_top);
        w_load_clamped = (bus.i_load_val < r_top) ? bus.i_load_val : r_top;
    end

    // Next-state, datapath and wrap decode; priority clr > load > start > enb
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_top_nxt   = r_top;
        w_dir_nxt   = r_dir;
        w_os_nxt    = r_os;
        w_wrap      = 1'b0;
        if (bus.i_clr) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
        end else if (bus.i_load) begin
            w_count_nxt = w_load_clamped;
        end else if (bus.i_start) begin
            w_top_nxt   = bus.i_top;
            w_dir_nxt   = bus.i_dir;
            w_os_nxt    = bus.i_oneshot;
            w_count_nxt = (bus.i_dir == CNT_DN) ? bus.i_top : '0;
            w_state_nxt = RUN;
        end else if ((r_state == RUN) && bus.i_enb) begin
            if (w_at_term) begin
                w_wrap = 1'b1;
                // One-shot parks on the terminal value instead of wrapping
                if (r_os) begin
                    w_state_nxt = DONE;
                end else begin
                    w_count_nxt = (r_dir == CNT_DN) ? r_top : '0;
                end
            end else begin
                w_count_nxt = (r_dir == CNT_DN) ? (r_count - DW'(1)) : (r_count + DW'(1));
            end
        end
    end

    // State, count and latched configuration registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_top   <= '1;
            r_dir   <= CNT_UP;
            r_os    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_top   <= w_top_nxt;
            r_dir   <= w_dir_nxt;
            r_os    <= w_os_nxt;
        end
    end

    // Sticky overflow; a wrap in the same cycle beats the clear request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end else if (bus.i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    cntr_wrap_sat #(
        .WW (WW)
    ) u_wrap_sat (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_wrap),
        .i_clr (bus.i_clr),
        .o_val (w_wraps)
    );

    assign bus.o_count = r_count;
    assign bus.o_tc    = (r_state == RUN) && w_at_term;
    assign bus.o_ovf   = r_ovf;
    assign bus.o_wraps = w_wraps;
    assign bus.o_busy  = (r_state == RUN);
    assign bus.o_done  = (r_state == DONE);
endmodule

// File: tb/tb_cntr_mod_n_prog.sv
// Randomized and directed bench for cntr_mod_n_prog against a modular-arithmetic model.
module tb_cntr_mod_n_prog;
    localparam int unsigned DW = 8;
    localparam int unsigned WW = 4;
    localparam int WMAX = (1 << WW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cntr_mod_n_prog_if #(.DW(DW), .WW(WW)) bus ();

    cntr_mod_n_prog #(.DW(DW), .WW(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus for the next cycle
    bit t_enb, t_clr, t_load, t_start, t_dir, t_os, t_ovfc;
    int t_lval, t_top;

    // Model: state 0 idle / 1 run / 2 done
    int m_st, m_cnt, m_top, m_dir, m_os, m_ovf, m_wr;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_top = (1 << DW) - 1;
        m_dir = 0; m_os = 0; m_ovf = 0; m_wr = 0;
    endtask

    task automatic model_step();
        bit wrap = 0;
        int modn;
        if (t_clr) begin
            m_st = 0; m_cnt = 0; m_wr = 0;
        end else if (t_load) begin
            m_cnt = (t_lval < m_top) ? t_lval : m_top;
        end else if (t_start) begin
            m_top = t_top; m_dir = int'(t_dir); m_os = int'(t_os);
            m_cnt = t_dir ? t_top : 0;
            m_st = 1;
        end else if (m_st == 1 && t_enb) begin
            modn = m_top + 1;
            wrap = (m_cnt == (m_dir ? 0 : m_top));
            if (wrap && m_os) m_st = 2;
            else m_cnt = m_dir ? (m_cnt + modn - 1) % modn : (m_cnt + 1) % modn;
        end
        if (wrap) begin
            m_ovf = 1;
            if (m_wr < WMAX) m_wr++;
        end else if (t_ovfc) begin
            m_ovf = 0;
        end
    endtask

    task automatic check_all();
        check("count", int'(bus.o_count), m_cnt);
        check("tc",    int'(bus.o_tc), int'(m_st == 1 && m_cnt == (m_dir ? 0 : m_top)));
        check("ovf",   int'(bus.o_ovf), m_ovf);
        check("wraps", int'(bus.o_wraps), m_wr);
        check("busy",  int'(bus.o_busy), int'(m_st == 1));
        check("done",  int'(bus.o_done), int'(m_st == 2));
    endtask

    task automatic apply();
        bus.i_enb      = t_enb;
        bus.i_clr      = t_clr;
        bus.i_load     = t_load;
        bus.i_load_val = DW'(t_lval);
        bus.i_start    = t_start;
        bus.i_top      = DW'(t_top);
        bus.i_dir      = t_dir;
        bus.i_oneshot  = t_os;
        bus.i_ovf_clr  = t_ovfc;
    endtask

    // One clock: drive, let DUT and model advance, compare away from the edge
    task automatic tick();
        apply();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        t_clr = 0; t_load = 0; t_start = 0; t_ovfc = 0;
    endtask

    task automatic do_start(input int top, input bit dir, input bit os);
        t_enb = 0; t_start = 1; t_top = top; t_dir = dir; t_os = os;
        tick();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_count"}, int'(bus.o_count), 0);
        check({tag, "_tc"},    int'(bus.o_tc), 0);
        check({tag, "_ovf"},   int'(bus.o_ovf), 0);
        check({tag, "_wraps"}, int'(bus.o_wraps), 0);
        check({tag, "_busy"},  int'(bus.o_busy), 0);
        check({tag, "_done"},  int'(bus.o_done), 0);
    endtask

    initial begin
        t_enb = 0; t_clr = 0; t_load = 0; t_start = 0; t_dir = 0; t_os = 0;
        t_ovfc = 0; t_lval = 0; t_top = 0;
        apply();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Continuous up, top 7, 20 enabled cycles
        do_start(7, 0, 0);
        t_enb = 1;
        for (int i = 0; i < 20; i++) tick();
        check("up7_count", int'(bus.o_count), 4);
        check("up7_wraps", int'(bus.o_wraps), 2);
        check("up7_ovf",   int'(bus.o_ovf), 1);

        // Clear keeps ovf; one-shot down from 5
        t_enb = 0; t_clr = 1; tick();
        check("clr_wraps", int'(bus.o_wraps), 0);
        check("clr_ovf",   int'(bus.o_ovf), 1);
        do_start(5, 1, 1);
        t_enb = 1;
        for (int i = 0; i < 6; i++) tick();
        check("os_dn_done",  int'(bus.o_done), 1);
        check("os_dn_busy",  int'(bus.o_busy), 0);
        check("os_dn_count", int'(bus.o_count), 0);
        check("os_dn_wraps", int'(bus.o_wraps), 1);
        for (int i = 0; i < 3; i++) tick();

        // Load clamp and mid-run config change, top 9
        do_start(9, 0, 0);
        t_enb = 1;
        for (int i = 0; i < 3; i++) tick();
        t_load = 1; t_lval = 12; tick();
        check("load_clamp", int'(bus.o_count), 9);
        check("load_tc",    int'(bus.o_tc), 1);
        t_top = 3; tick();
        check("cfg_fixed_count", int'(bus.o_count), 0);
        check("cfg_fixed_wraps", int'(bus.o_wraps), 2);
        for (int i = 0; i < 5; i++) tick();

        // Collisions
        t_clr = 1; t_load = 1; t_lval = 5; tick();
        check("clr_load_busy",  int'(bus.o_busy), 0);
        check("clr_load_count", int'(bus.o_count), 0);
        t_enb = 0; t_ovfc = 1; tick();
        check("ovfclr", int'(bus.o_ovf), 0);
        do_start(0, 0, 0);
        t_enb = 1; t_ovfc = 1; tick();
        check("ovf_set_wins", int'(bus.o_ovf), 1);

        // Saturation with modulus 1, then async reset mid-run
        t_enb = 0; t_clr = 1; tick();
        do_start(0, 0, 0);
        t_enb = 1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_wraps", int'(bus.o_wraps), WMAX);
        check("sat_count", int'(bus.o_count), 0);
        do_start(9, 0, 0);
        t_enb = 1;
        for (int i = 0; i < 4; i++) tick();
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("post_rst_count", int'(bus.o_count), 0);

        // Enable gating, then DONE ignores enb and restart re-latches dir
        do_start(7, 0, 0);
        for (int i = 0; i < 10; i++) begin
            t_enb = (i % 2 == 0);
            tick();
        end
        check("gate_count", int'(bus.o_count), 5);
        do_start(2, 0, 1);
        t_enb = 1;
        for (int i = 0; i < 6; i++) tick();
        check("os_up_done", int'(bus.o_done), 1);
        check("os_up_hold", int'(bus.o_count), 2);
        do_start(4, 1, 0);
        check("restart_count", int'(bus.o_count), 4);
        check("restart_busy",  int'(bus.o_busy), 1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            t_enb   = ($urandom_range(0, 9) < 7);
            t_clr   = ($urandom_range(0, 59) == 0);
            t_load  = ($urandom_range(0, 14) == 0);
            t_start = ($urandom_range(0, 13) == 0);
            t_ovfc  = ($urandom_range(0, 9) == 0);
            t_lval  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 14));
            t_top   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 12));
            t_dir   = 1'($urandom_range(0, 1));
            t_os    = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
